// File: rtl/muldiv_ctrl_pkg.sv
// Shared processor definitions: control-unit opcodes, the mult/div controller
// state encoding and the datapath word width.
package muldiv_ctrl_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_MULT = 2'b01,
        OP_DIV  = 2'b10,
        OP_RSVD = 2'b11
    } op_code_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_WRITE
    } state_t;

    // Reserved and none encodings both mean "nothing to do".
    function automatic logic op_is_active(input logic [1:0] code);
        return (code == OP_MULT) || (code == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_hilo_reg.sv
// HI/LO architectural register pair: two 32-bit words sharing one write
// enable, cleared by the synchronous active-low reset.
module hilo_reg
    import muldiv_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [WORD_W-1:0] hi_d,
    input  logic [WORD_W-1:0] lo_d,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo
);

    logic [WORD_W-1:0] din  [2];
    logic [WORD_W-1:0] word [2];

    assign din[0] = lo_d;
    assign din[1] = hi_d;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_word
            logic [WORD_W-1:0] word_reg;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    word_reg <= '0;
                end else if (we) begin
                    word_reg <= din[gi];
                end
            end

            assign word[gi] = word_reg;
        end
    endgenerate

    assign lo = word[0];
    assign hi = word[1];

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequences one MULT or DIV through the external units: latch operands, launch,
// wait for the selected unit's done (bounded by TIMEOUT), then write HI/LO.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [1:0]        op_code,
    input  logic [WORD_W-1:0] op_a,
    input  logic [WORD_W-1:0] op_b,
    output logic              stall,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo,
    output logic              dbz_exc,
    output logic              timeout_exc,
    output logic              div_start,
    output logic [WORD_W-1:0] div_a,
    output logic [WORD_W-1:0] div_b,
    input  logic              div_busy,
    input  logic              div_done,
    input  logic              div_dbz,
    input  logic [WORD_W-1:0] div_val,
    input  logic [WORD_W-1:0] div_rem,
    output logic              mult_start,
    output logic [WORD_W-1:0] mult_a,
    output logic [WORD_W-1:0] mult_b,
    input  logic              mult_done,
    input  logic [WORD_W-1:0] mult_hi,
    input  logic [WORD_W-1:0] mult_lo
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state_reg, state_next;
    op_code_t          op_reg, op_next;
    logic [WORD_W-1:0] a_reg, a_next;
    logic [WORD_W-1:0] b_reg, b_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              timeout_reg, timeout_next;

    logic              accept;
    logic              is_div;
    logic              sel_done;
    logic              hilo_we;
    logic [WORD_W-1:0] hi_d, lo_d;

    assign accept   = (state_reg == ST_IDLE) && op_valid && op_is_active(op_code);
    assign is_div   = (op_reg == OP_DIV);
    assign sel_done = is_div ? div_done : mult_done;
    assign hi_d     = is_div ? div_rem : mult_hi;
    assign lo_d     = is_div ? div_val : mult_lo;

    assign div_a       = a_reg;
    assign div_b       = b_reg;
    assign mult_a      = a_reg;
    assign mult_b      = b_reg;
    assign timeout_exc = timeout_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            op_reg      <= OP_NONE;
            a_reg       <= '0;
            b_reg       <= '0;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        cnt_next     = cnt_reg;
        timeout_next = 1'b0;
        stall        = 1'b0;
        div_start    = 1'b0;
        mult_start   = 1'b0;
        dbz_exc      = 1'b0;
        hilo_we      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    stall      = 1'b1;
                    op_next    = op_code_t'(op_code);
                    a_next     = op_a;
                    b_next     = op_b;
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                stall    = 1'b1;
                cnt_next = '0;
                // A busy divider defers the launch; the multiplier never does.
                if (!(is_div && div_busy)) begin
                    div_start  = is_div;
                    mult_start = !is_div;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall    = 1'b1;
                cnt_next = cnt_reg + CNT_W'(1);
                // done wins over a timeout landing on the same cycle
                if (sel_done) begin
                    state_next = ST_WRITE;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    timeout_next = 1'b1;
                    cnt_next     = '0;
                    state_next   = ST_IDLE;
                end
            end
            ST_WRITE: begin
                stall      = 1'b1;
                dbz_exc    = is_div && div_dbz;
                hilo_we    = !(is_div && div_dbz);
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    hilo_reg u_hilo (
        .clk  (clk),
        .rst  (rst),
        .we   (hilo_we),
        .hi_d (hi_d),
        .lo_d (lo_d),
        .hi   (hi),
        .lo   (lo)
    );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed and randomized checks of muldiv_ctrl; the bench plays both
// arithmetic units and predicts timing and HI/LO from plain arithmetic.
module tb_muldiv_ctrl;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [1:0]  op_code = 2'b00;
    logic [31:0] op_a = '0, op_b = '0;
    logic        stall, dbz_exc, timeout_exc;
    logic [31:0] hi, lo;
    logic        div_start, mult_start;
    logic [31:0] div_a, div_b, mult_a, mult_b;
    logic        div_busy = 1'b0, div_done = 1'b0, div_dbz = 1'b0;
    logic [31:0] div_val = '0, div_rem = '0;
    logic        mult_done = 1'b0;
    logic [31:0] mult_hi = '0, mult_lo = '0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    muldiv_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
        .op_a(op_a), .op_b(op_b), .stall(stall), .hi(hi), .lo(lo),
        .dbz_exc(dbz_exc), .timeout_exc(timeout_exc),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_busy(div_busy), .div_done(div_done), .div_dbz(div_dbz),
        .div_val(div_val), .div_rem(div_rem),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction from the accept cycle (cycle 0) to the first IDLE cycle.
    // lat = cycles from start pulse to done (0 = unit never answers).
    task automatic run_op(input string name, input logic [1:0] code,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int busy, input bit dbz);
        bit                 is_div    = (code == 2'b10);
        int                 start_cyc = 1 + busy;
        int                 done_cyc  = (lat == 0) ? -1 : start_cyc + lat;
        int                 end_cyc   = (lat == 0) ? start_cyc + 1 + TIMEOUT : done_cyc + 2;
        bit                 writes    = (lat != 0) && !(is_div && dbz);
        bit                 have_res;
        logic signed [31:0] sa, sb;
        logic [31:0]        r_hi = '0, r_lo = '0;
        longint             p;
        int                 n_div = 0, n_mult = 0;

        sa = a;
        sb = b;
        if (is_div) begin
            if (!dbz) begin
                r_lo = sa / sb;
                r_hi = sa % sb;
            end
        end else begin
            p    = longint'(sa) * longint'(sb);
            r_hi = p[63:32];
            r_lo = p[31:0];
        end

        for (int cyc = 0; cyc <= end_cyc; cyc++) begin
            if (cyc == 0) begin
                op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
            end else if (cyc == end_cyc) begin
                op_valid = 1'b1;
                op_code  = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
                op_a = $urandom; op_b = $urandom;
            end else begin
                op_valid = 1'($urandom_range(0, 1));
                op_code  = 2'($urandom);
                op_a = $urandom; op_b = $urandom;
            end
            have_res = (done_cyc >= 0) && (cyc >= done_cyc);
            div_busy = is_div && (cyc >= 1) && (cyc < start_cyc);
            if (is_div) begin
                div_done  = (cyc == done_cyc);
                div_dbz   = have_res ? dbz : 1'b0;
                div_val   = have_res ? r_lo : $urandom;
                div_rem   = have_res ? r_hi : $urandom;
                mult_done = 1'($urandom_range(0, 1));
                mult_hi   = $urandom;
                mult_lo   = $urandom;
            end else begin
                mult_done = (cyc == done_cyc);
                mult_hi   = have_res ? r_hi : $urandom;
                mult_lo   = have_res ? r_lo : $urandom;
                div_done  = 1'($urandom_range(0, 1));
                div_dbz   = 1'($urandom_range(0, 1));
                div_val   = $urandom;
                div_rem   = $urandom;
            end
            #3;
            if (cyc == end_cyc && writes) begin
                exp_hi = r_hi;
                exp_lo = r_lo;
            end
            chk($sformatf("%s_stall@%0d", name, cyc), stall, cyc < end_cyc);
            chk($sformatf("%s_div_start@%0d", name, cyc), div_start, is_div && cyc == start_cyc);
            chk($sformatf("%s_mult_start@%0d", name, cyc), mult_start, !is_div && cyc == start_cyc);
            chk($sformatf("%s_dbz_exc@%0d", name, cyc), dbz_exc,
                is_div && dbz && lat != 0 && cyc == done_cyc + 1);
            chk($sformatf("%s_timeout_exc@%0d", name, cyc), timeout_exc, lat == 0 && cyc == end_cyc);
            chk($sformatf("%s_hi@%0d", name, cyc), hi, exp_hi);
            chk($sformatf("%s_lo@%0d", name, cyc), lo, exp_lo);
            if (cyc >= 1 && cyc < end_cyc) begin
                chk($sformatf("%s_div_ops@%0d", name, cyc), {div_a, div_b}, {a, b});
                chk($sformatf("%s_mult_ops@%0d", name, cyc), {mult_a, mult_b}, {a, b});
            end
            n_div  += int'(div_start);
            n_mult += int'(mult_start);
            tick();
        end
        chk({name, "_div_start_count"}, 64'(n_div), is_div ? 64'd1 : 64'd0);
        chk({name, "_mult_start_count"}, 64'(n_mult), is_div ? 64'd0 : 64'd1);
        $display("op %s code=%0d a=%0h b=%0h lat=%0d busy=%0d -> hi=%0h lo=%0h",
                 name, code, a, b, lat, busy, hi, lo);
    endtask

    initial begin
        logic [1:0]  rcode;
        logic [31:0] ra, rb;
        bit          rdbz;

        // reset state
        rst = 1'b0;
        tick();
        tick();
        #3;
        chk("rst_stall", stall, 1'b0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_starts", {div_start, mult_start}, 2'b00);
        chk("rst_exc", {dbz_exc, timeout_exc}, 2'b00);
        tick();
        rst = 1'b1;
        tick();

        run_op("div7000_7", 2'b10, 32'd7000, 32'd7, 3, 0, 1'b0);
        chk("div7000_7_lo_const", lo, 32'd1000);
        chk("div7000_7_hi_const", hi, 32'd0);

        run_op("div5000_m3", 2'b10, 32'd5000, 32'hFFFF_FFFD, 5, 2, 1'b0);
        chk("div5000_m3_lo_const", lo, 32'hFFFF_F97E);
        chk("div5000_m3_hi_const", hi, 32'd2);

        run_op("div4000_0", 2'b10, 32'd4000, 32'd0, 2, 0, 1'b1);
        chk("div4000_0_lo_kept", lo, 32'hFFFF_F97E);
        chk("div4000_0_hi_kept", hi, 32'd2);

        run_op("mult_10000", 2'b01, 32'h0001_0000, 32'h0001_0000, 4, 0, 1'b0);
        chk("mult_10000_hi_const", hi, 32'd1);
        chk("mult_10000_lo_const", lo, 32'd0);

        run_op("div_hang", 2'b10, 32'd100, 32'd7, 0, 1, 1'b0);
        run_op("div_done_at_limit", 2'b10, 32'd123456, 32'hFFFF_FFF5, TIMEOUT, 0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            rcode = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
            ra    = $urandom;
            rb    = $urandom;
            rdbz  = 1'b0;
            if (rcode == 2'b10) begin
                if ($urandom_range(0, 4) == 0) begin
                    rb   = 32'd0;
                    rdbz = 1'b1;
                end else if (rb == 32'd0 || rb == 32'hFFFF_FFFF) begin
                    rb = 32'd5;
                end
            end
            run_op($sformatf("rand%0d", i), rcode, ra, rb, $urandom_range(1, 6),
                   (rcode == 2'b10) ? $urandom_range(0, 2) : 0, rdbz);
        end

        // reset while waiting on the divider, then a late done
        op_valid = 1'b1; op_code = 2'b10; op_a = 32'd12; op_b = 32'd4;
        div_done = 1'b0; mult_done = 1'b0; div_busy = 1'b0; div_dbz = 1'b0;
        tick();
        op_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        div_done = 1'b1; div_val = 32'd3; div_rem = 32'd0;
        #3;
        chk("rstwait_stall", stall, 1'b0);
        chk("rstwait_hi", hi, 32'd0);
        chk("rstwait_lo", lo, 32'd0);
        tick();
        div_done = 1'b0;
        #3;
        chk("rstwait_late_stall", stall, 1'b0);
        chk("rstwait_late_hilo", {hi, lo}, 64'd0);
        $display("op rst_mid_wait -> hi=%0h lo=%0h stall=%0b", hi, lo, stall);
        exp_hi = '0;
        exp_lo = '0;
        tick();

        run_op("div9000_3", 2'b10, 32'd9000, 32'd3, 2, 0, 1'b0);
        chk("div9000_3_lo_const", lo, 32'd3000);
        op_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
